// File: rtl/timer_pkg.sv
// Shared types and defaults for the shared one-shot timer block.
// Imported by the arbiter top and its down-counter datapath.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tsa_state_t;

  localparam int CW_DEF   = 4;
  localparam int NREQ_DEF = 4;

endpackage

// File: rtl/timer_share_arb_down_counter.sv
// Loadable down-counter that saturates at zero.
// Clear beats load, load beats decrement.
module down_counter
  import timer_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign zero  = (count_q == '0);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      clr:         count_d = '0;
      load:        count_d = load_val;
      en && !zero: count_d = count_q - 1'b1;
      default:     count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/timer_share_arb.sv
// Round-robin owner of one shared down-counter for NREQ requesters.
// Accept and done strobes are combinational in the cycle they occur.
module timer_share_arb
  import timer_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*CW-1:0] req_ticks,
  output logic [NREQ-1:0]    req_ready,
  input  logic               abort,
  output logic [NREQ-1:0]    done_pulse,
  output logic               busy,
  output logic [IW-1:0]      owner,
  output logic [CW-1:0]      count
);

  tsa_state_t    state_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] rr_last_q;

  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic [IW:0]   scan;
  logic          accept;
  logic          done;
  logic          zero;
  logic [CW-1:0] load_val;
  logic          run;

  // Scan starts one past the last winner and wraps.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    scan    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan = {1'b0, rr_last_q} + (IW+1)'(k);
      if (int'(scan) >= NREQ) begin
        scan = scan - (IW+1)'(NREQ);
      end
      if (!gnt_any && req_valid[scan[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[IW-1:0];
      end
    end
  end

  assign run      = (state_q == RUN);
  assign accept   = rst_n && !run && gnt_any;
  assign done     = run && zero && !abort;
  assign load_val = req_ticks[int'(gnt_idx)*CW +: CW];

  assign req_ready  = accept ? (NREQ'(1) << gnt_idx) : '0;
  assign done_pulse = done ? (NREQ'(1) << owner_q) : '0;
  assign busy       = run;
  assign owner      = owner_q;

  down_counter #(
    .CW(CW)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .load_val(load_val),
    .en      (run && !abort),
    .clr     (run && abort),
    .count   (count),
    .zero    (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_last_q <= IW'(NREQ - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= RUN;
            owner_q   <= gnt_idx;
            rr_last_q <= gnt_idx;
          end
        end
        RUN: begin
          if (abort || zero) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_share_arb.sv
// Random and directed checks of timer_share_arb against a
// timestamp-based model of accept/done scheduling.
module tb_timer_share_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_ticks;
  logic [3:0]  req_ready;
  logic        abort;
  logic [3:0]  done_pulse;
  logic        busy;
  logic [1:0]  owner;
  logic [3:0]  count;

  int checks;
  int failures;

  timer_share_arb #(
    .NREQ(4),
    .CW  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ticks (req_ticks),
    .req_ready (req_ready),
    .abort     (abort),
    .done_pulse(done_pulse),
    .busy      (busy),
    .owner     (owner),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: a run is a window [acc+1, acc+1+n] in step-number time.
  int m_act;
  int m_acc;
  int m_n;
  int m_dc;
  int m_own;
  int m_rr;
  int cyc;

  task automatic step(input logic r, input logic [3:0] v,
                      input logic [15:0] t, input logic ab);
    int e_cnt;
    int g;
    logic [3:0] e_rdy;
    logic [3:0] e_done;
    @(negedge clk);
    rst_n     = r;
    req_valid = v;
    req_ticks = t;
    abort     = ab;
    #1;
    if (!r) begin
      m_act = 0;
      m_own = 0;
      m_rr  = 3;
    end
    e_rdy  = '0;
    e_done = '0;
    e_cnt  = 0;
    g      = -1;
    if (m_act != 0) begin
      e_cnt = m_n - (cyc - m_acc - 1);
      if (e_cnt < 0) e_cnt = 0;
      if (!ab && cyc == m_dc) e_done = 4'(1 << m_own);
    end else if (r) begin
      for (int k = 1; k <= 4; k++) begin
        if (g < 0 && v[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      end
      if (g >= 0) e_rdy = 4'(1 << g);
    end
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("done_pulse", 32'(done_pulse), 32'(e_done));
    chk("busy", 32'(busy), 32'(m_act != 0));
    chk("count", 32'(count), 32'(e_cnt));
    chk("owner", 32'(owner), 32'(m_own));
    chk("rdy_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    if (m_act != 0) begin
      if (ab || cyc == m_dc) m_act = 0;
    end else if (g >= 0) begin
      m_act = 1;
      m_acc = cyc;
      m_n   = int'(t[g*4 +: 4]);
      m_dc  = cyc + 1 + m_n;
      m_own = g;
      m_rr  = g;
    end
    cyc++;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    m_act     = 0;
    m_own     = 0;
    m_rr      = 3;
    m_acc     = 0;
    m_n       = 0;
    m_dc      = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_ticks = '0;
    abort     = 1'b0;

    repeat (2) step(1'b0, 4'b0000, 16'h0000, 1'b0);
    // ticks=3 on req 0
    step(1'b1, 4'b0001, 16'h0003, 1'b0);
    repeat (6) step(1'b1, 4'b0000, 16'h0003, 1'b0);
    // ticks=0 on req 2
    step(1'b1, 4'b0100, 16'h0000, 1'b0);
    repeat (3) step(1'b1, 4'b0000, 16'h0000, 1'b0);
    // 0 and 2 held from reset
    step(1'b0, 4'b0000, 16'h0000, 1'b0);
    repeat (14) step(1'b1, 4'b0101, 16'h0202, 1'b0);
    // all four, ticks=1
    step(1'b0, 4'b0000, 16'h0000, 1'b0);
    repeat (16) step(1'b1, 4'b1111, 16'h1111, 1'b0);
    // abort a long run with req 3 waiting
    step(1'b0, 4'b0000, 16'h0000, 1'b0);
    step(1'b1, 4'b0010, 16'h00F0, 1'b0);
    repeat (4) step(1'b1, 4'b1000, 16'h50F0, 1'b0);
    step(1'b1, 4'b1000, 16'h50F0, 1'b1);
    repeat (8) step(1'b1, 4'b1000, 16'h50F0, 1'b0);
    // reset mid-run, then req 0 first
    step(1'b1, 4'b0010, 16'h00A0, 1'b0);
    repeat (3) step(1'b1, 4'b0000, 16'h0000, 1'b0);
    step(1'b0, 4'b1111, 16'h1111, 1'b0);
    repeat (4) step(1'b1, 4'b1111, 16'h1111, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0),
           4'($urandom_range(0, 15)),
           16'($urandom),
           ($urandom_range(0, 24) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
